// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with one-entry skid buffer, flush-to-bubble and saturating stall counter
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              acc, pop;

    assign acc       = in_valid & ~skid_valid;
    assign pop       = main_valid & out_ready;
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else if (!main_valid || pop) begin
            // skid always drains ahead of new input to keep ordering
            if (skid_valid) begin
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end else if (acc) begin
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && !flush && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed checks of streaming, backpressure, flush, bubble, reset and counter saturation
module tb_pipe_skid_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [8:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;
    int          checks = 0;
    int          errors = 0;

    pipe_skid_stage #(.DATA_W(64), .CTRL_W(9), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [8:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0, 9'h0);
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall_cnt, 0);

        // streaming at full rate
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 9'(i));
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, 64'(i));
            chk("stream_ctrl", out_ctrl, 64'(i));
            chk("stream_ready", in_ready, 1);
            chk("stream_occ", occupancy, 1);
        end
        drive(1'b0, 64'h0, 9'h0);
        tick();
        chk("stream_drain", out_valid, 0);
        chk("stream_stall", stall_cnt, 0);

        // backpressure with A, B, C
        out_ready = 1'b0;
        drive(1'b1, 64'hA, 9'h1);
        tick();
        chk("bp_a_data", out_data, 64'hA);
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_ready", in_ready, 1);
        drive(1'b1, 64'hB, 9'h2);
        tick();
        chk("bp_b_occ", occupancy, 2);
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_data", out_data, 64'hA);
        chk("bp_b_stall", stall_cnt, 1);
        drive(1'b1, 64'hC, 9'h3);
        tick();
        chk("bp_c_held", out_data, 64'hA);
        chk("bp_c_occ", occupancy, 2);
        tick();
        chk("bp_stall3", stall_cnt, 3);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_b", out_data, 64'hB);
        chk("bp_rel_ctrl", out_ctrl, 2);
        chk("bp_rel_ready", in_ready, 1);
        chk("bp_rel_occ", occupancy, 1);
        tick();
        chk("bp_rel_c", out_data, 64'hC);
        chk("bp_rel_c_valid", out_valid, 1);
        drive(1'b0, 64'h0, 9'h0);
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_final", stall_cnt, 3);

        // flush with two held entries and a new one offered
        out_ready = 1'b0;
        drive(1'b1, 64'hD, 9'h1FF);
        tick();
        drive(1'b1, 64'hE, 9'h1FF);
        tick();
        chk("fl_occ2", occupancy, 2);
        drive(1'b1, 64'hF, 9'h1FF);
        flush = 1'b1;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_stall", stall_cnt, 4);
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 64'h0, 9'h0);
        tick();
        chk("fl_dropped", out_valid, 0);
        chk("fl_data_kept", out_data, 64'hD);

        // bubble with stale control
        drive(1'b0, 64'h55, 9'h1FF);
        tick();
        chk("bub_valid", out_valid, 0);
        chk("bub_ctrl", out_ctrl, 0);

        // reset beats flush mid-stall
        out_ready = 1'b0;
        drive(1'b1, 64'h6, 9'h6);
        tick();
        drive(1'b1, 64'h7, 9'h7);
        tick();
        chk("rs_occ2", occupancy, 2);
        rst = 1'b1; flush = 1'b1;
        tick();
        chk("rs_valid", out_valid, 0);
        chk("rs_ready", in_ready, 1);
        chk("rs_data", out_data, 0);
        chk("rs_ctrl", out_ctrl, 0);
        chk("rs_occ", occupancy, 0);
        chk("rs_stall", stall_cnt, 0);
        rst = 1'b0; flush = 1'b0;

        // stall counter saturation
        drive(1'b1, 64'h9, 9'h9);
        tick();
        drive(1'b0, 64'h0, 9'h0);
        repeat (14) tick();
        chk("sat_14", stall_cnt, 14);
        repeat (6) tick();
        chk("sat_15", stall_cnt, 15);
        chk("sat_held", out_data, 64'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
